// File: rtl/pwm_multi_if.sv
// pwm_multi_if: control/status bundle for the multi-channel PWM.
//   master : drives enable, load, period, duty, center_mode, polarity;
//            observes pulse, cycle_start, pending
//   slave  : the PWM block (mirror of master)
// duty packs channel i in bits [i*WIDTH +: WIDTH].
interface pwm_multi_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 17
);
    logic                        enable;
    logic                        load;
    logic [WIDTH-1:0]            period;
    logic [CHANNELS*WIDTH-1:0]   duty;
    logic                        center_mode;
    logic [CHANNELS-1:0]         polarity;
    logic [CHANNELS-1:0]         pulse;
    logic                        cycle_start;
    logic                        pending;

    modport master (
        output enable, load, period, duty, center_mode, polarity,
        input  pulse, cycle_start, pending
    );

    modport slave (
        input  enable, load, period, duty, center_mode, polarity,
        output pulse, cycle_start, pending
    );
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM sharing one period counter.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : pwm_multi_if.slave
//     enable       run/hold the shared counter
//     load         strobe capturing period/duty/center_mode into staging
//     period, duty, center_mode   staged values, applied at a period boundary
//     polarity     live per-channel invert
//     pulse        registered outputs, cycle_start first-cycle strobe,
//     pending      staged values not yet applied
// pwm_lane holds one channel's staged/active duty and its output register.

module pwm_lane #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             xfer,
    input  logic             run,
    input  logic             polarity,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty_in,
    output logic             pulse
);
    logic [WIDTH-1:0] duty_s, duty_a;

    // On a transfer edge the active duty still drives this cycle's
    // sample; the new value is seen from cnt=0 of the next period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_s <= '0;
            duty_a <= '0;
            pulse  <= 1'b0;
        end else begin
            if (xfer) duty_a <= duty_s;
            if (load) duty_s <= duty_in;
            pulse <= (run && (cnt < duty_a)) ^ polarity;
        end
    end
endmodule

module pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    pwm_multi_if.slave  bus
);
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    logic [WIDTH-1:0]                 period_s, period_a;
    logic                             mode_s, mode_a;
    logic [WIDTH-1:0]                 cnt, cnt_nxt, last;
    dir_t                             dir, dir_nxt;
    logic                             pending, cs_q;
    logic                             running, boundary, xfer;
    logic [CHANNELS-1:0][WIDTH-1:0]   duty_v;
    logic [CHANNELS-1:0]              pulse_w;

    assign duty_v  = bus.duty;
    assign last    = period_a - ONE;
    assign running = bus.enable && (period_a >= TWO);

    // Last cycle of a period. A center-mode period of 2 never goes down,
    // so its turn-around point doubles as the boundary.
    always_comb begin
        boundary = 1'b0;
        if (!mode_a)
            boundary = (cnt == last);
        else
            boundary = ((dir == DOWN) && (cnt == ONE)) ||
                       ((dir == UP) && (cnt == last) && (period_a == TWO));
    end

    // Idle: apply staged values on the next edge. Running: only at a boundary.
    assign xfer = pending && (!running || boundary);

    always_comb begin
        cnt_nxt = '0;
        dir_nxt = UP;
        if (running && !boundary) begin
            if (!mode_a) begin
                cnt_nxt = cnt + ONE;
            end else if (dir == UP) begin
                if (cnt == last) begin
                    cnt_nxt = cnt - ONE;
                    dir_nxt = DOWN;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end else begin
                cnt_nxt = cnt - ONE;
                dir_nxt = DOWN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_s <= '0;
            period_a <= '0;
            mode_s   <= 1'b0;
            mode_a   <= 1'b0;
            cnt      <= '0;
            dir      <= UP;
            pending  <= 1'b0;
            cs_q     <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
            if (xfer) begin
                period_a <= period_s;
                mode_a   <= mode_s;
            end
            // A load coincident with a transfer only refills staging.
            if (bus.load) begin
                period_s <= bus.period;
                mode_s   <= bus.center_mode;
            end
            pending <= bus.load | (pending & ~xfer);
            cs_q    <= running && (cnt == '0);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        pwm_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (bus.load),
            .xfer     (xfer),
            .run      (running),
            .polarity (bus.polarity[g]),
            .cnt      (cnt),
            .duty_in  (duty_v[g]),
            .pulse    (pulse_w[g])
        );
    end

    assign bus.pulse       = pulse_w;
    assign bus.cycle_start = cs_q;
    assign bus.pending     = pending;
endmodule
